// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble encoding, default reset PC and the
// instruction-queue entry layout handed to the IF/ID register.
package pipe_pkg;

    localparam logic [31:0] NOP_INST         = 32'hff000000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with push/pop/flush, occupancy count and full/empty flags.
// Push and pop may coincide at any occupancy, including full.
module inst_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign dout    = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is never reset; a slot is only read once count marks it live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= din;
        end
    end

    // Pointers and occupancy; flush discards everything including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order reads, queues returned
// words with their PC+4 and feeds the IF/ID register. Wrong-path responses that
// are still in flight at a redirect are discarded through the drop counter.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_out,
    output logic [31:0] pc4_out,
    output logic        inst_valid
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] CREDITS = CW1'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    logic [63:0]   q_dout;
    fetch_entry_t  q_head;
    fetch_entry_t  q_din;

    logic [CW-1:0] t_count;
    logic          t_full;
    logic          t_empty;
    logic [31:0]   tag_pc;

    logic [CW:0]   credit_used;
    logic          issue;
    logic          push;
    logic          pop;
    logic          consume;

    // Credit covers both queued words and requests still owed by memory,
    // so a returning word always finds room.
    assign credit_used = CW1'(q_count) + CW1'(outstanding);
    assign imem_req    = !rst && !redirect && (credit_used < CREDITS);
    assign imem_addr   = {pc[31:2], 2'b00};
    assign issue       = imem_req && imem_ready;

    assign consume     = imem_rvalid && (drop != '0);
    assign push        = imem_rvalid && !redirect && (drop == '0);
    assign q_din       = '{inst: imem_rdata, pc4: tag_pc + 32'd4};
    assign q_head      = fetch_entry_t'(q_dout);

    assign inst_valid  = !rst && !redirect && !q_empty;
    assign pop         = inst_valid && !stall;

    // Head entry, or the bubble whenever nothing real can be presented.
    always_comb begin
        inst_out = NOP_INST;
        pc4_out  = '0;
        if (inst_valid) begin
            inst_out = q_head.inst;
            pc4_out  = q_head.pc4;
        end
    end

    // PC, in-flight and drop bookkeeping; a redirect marks every request
    // still in flight after this edge as wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (redirect) begin
                pc   <= redirect_pc;
                drop <= outstanding - CW'(imem_rvalid);
            end else begin
                if (issue)   pc   <= pc + 32'd4;
                if (consume) drop <= drop - CW'(1);
            end
        end
    end

    inst_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_data_q (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (q_din),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Fetch PC of each in-flight request; dropped responses still retire their tag.
    inst_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (imem_rvalid),
        .flush (1'b0),
        .din   (pc),
        .dout  (tag_pc),
        .count (t_count),
        .full  (t_full),
        .empty (t_empty)
    );

    a_tag_matches_outstanding: assert property (@(posedge clk) disable iff (rst)
        t_count == outstanding);
    a_no_orphan_response: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && t_empty));
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
        !(issue && t_full));
    a_no_data_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && q_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: an in-order memory with programmable latency, a
// queue-based reference model compared every cycle, and directed scenarios
// with hand-derived literal expectations.
module tb_fetch_stage;
    import pipe_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst_out;
    logic [31:0] pc4_out;
    logic        inst_valid;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'h00000000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_out    (inst_out),
        .pc4_out     (pc4_out),
        .inst_valid  (inst_valid)
    );

    // Second instance exercising a reset PC near the top of the address space.
    logic        rst_b = 1'b1;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_rvalid = 1'b0;
    logic [31:0] b_rdata = 32'h0;
    logic [31:0] b_inst;
    logic [31:0] b_pc4;
    logic        b_valid;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) dut_w (
        .clk         (clk),
        .rst         (rst_b),
        .imem_req    (b_req),
        .imem_addr   (b_addr),
        .imem_ready  (1'b1),
        .imem_rvalid (b_rvalid),
        .imem_rdata  (b_rdata),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .inst_out    (b_inst),
        .pc4_out     (b_pc4),
        .inst_valid  (b_valid)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: a recognisable word derived from the address, never the bubble.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h13000000 | (a & 32'h00FFFFFF);
    endfunction

    // ---------------- memory for the main instance ----------------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int    cyc = 0;
    int    lat = 1;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mem_q.delete();
        end else begin
            if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
            if (imem_req && imem_ready) mem_q.push_back('{addr: imem_addr, due: cyc - 1 + lat});
        end
        #1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // ---------------- latency-1 memory for the second instance ----------------
    logic        b_iss;
    logic [31:0] b_a;
    always @(posedge clk) begin
        b_iss = b_req && !rst_b;
        b_a   = b_addr;
        #1;
        b_rvalid = b_iss;
        b_rdata  = memf(b_a);
    end

    // ---------------- reference model ----------------
    // Fetched words waiting for IF/ID, plus the list of requests memory still
    // owes us, each flagged dead once a redirect has made it wrong-path.
    typedef struct { logic [31:0] inst; logic [31:0] pc4; } qent_t;
    typedef struct { logic [31:0] pc; bit dead; } flight_t;
    qent_t       m_q[$];
    flight_t     m_fl[$];
    logic [31:0] m_pc = 32'h0;
    bit          started = 1'b0;

    function automatic bit m_req();
        return !rst && !redirect && ((m_q.size() + m_fl.size()) < DEPTH);
    endfunction

    function automatic bit m_valid();
        return !rst && !redirect && (m_q.size() > 0);
    endfunction

    always @(posedge clk) begin
        bit      v;
        bit      r;
        flight_t f;
        v = m_valid();
        r = m_req();
        if (rst) begin
            m_pc = 32'h0;
            m_q.delete();
            m_fl.delete();
            started = 1'b1;
        end else begin
            if (v && !stall) void'(m_q.pop_front());
            if (imem_rvalid) begin
                chk("resp_has_request", (m_fl.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (m_fl.size() > 0) begin
                    f = m_fl.pop_front();
                    if (!f.dead && !redirect) m_q.push_back('{inst: memf(f.pc), pc4: f.pc + 32'd4});
                end
            end
            if (r && imem_ready) begin
                m_fl.push_back('{pc: m_pc, dead: 1'b0});
                m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                m_q.delete();
                foreach (m_fl[i]) m_fl[i].dead = 1'b1;
                m_pc = redirect_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit r;
            bit v;
            r = m_req();
            v = m_valid();
            chk("imem_req", {31'd0, imem_req}, {31'd0, r});
            if (r) chk("imem_addr", imem_addr, {m_pc[31:2], 2'b00});
            chk("inst_valid", {31'd0, inst_valid}, {31'd0, v});
            chk("inst_out", inst_out, v ? m_q[0].inst : NOP_INST);
            chk("pc4_out", pc4_out, v ? m_q[0].pc4 : 32'h0);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;

        // 1: latency 1, always ready; reset cycle is cycle 0
        step();
        rst = 1'b0;                                  // cycle 1
        step();                                      // cycle 2
        step();                                      // cycle 3
        @(negedge clk);
        chk("t1_c3_inst", inst_out, 32'h13000000);
        chk("t1_c3_pc4", pc4_out, 32'h00000004);
        step();                                      // cycle 4
        @(negedge clk);
        chk("t1_c4_inst", inst_out, 32'h13000004);
        chk("t1_c4_pc4", pc4_out, 32'h00000008);
        step();                                      // cycle 5
        @(negedge clk);
        chk("t1_c5_inst", inst_out, 32'h13000008);
        chk("t1_c5_pc4", pc4_out, 32'h0000000C);
        chk("t1_c5_valid", {31'd0, inst_valid}, 32'd1);

        // 2: stall for cycles 6..11 with head at 0xC
        step();
        stall = 1'b1;                                // cycle 6
        repeat (3) step();                           // cycle 9
        @(negedge clk);
        chk("t2_c9_req", {31'd0, imem_req}, 32'd0);
        repeat (2) step();                           // cycle 11
        @(negedge clk);
        chk("t2_c11_req", {31'd0, imem_req}, 32'd0);
        chk("t2_c11_inst", inst_out, 32'h1300000C);
        step();
        stall = 1'b0;                                // cycle 12
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_drain_inst", inst_out, 32'h1300000C + 32'(4 * k));
            chk("t2_drain_pc4", pc4_out, 32'h00000010 + 32'(4 * k));
            step();
        end

        // 3: latency 3, redirect to 0x100 with two requests in flight
        rst = 1'b1;
        lat = 3;
        step();
        rst = 1'b0;                                  // cycle 1
        step();                                      // cycle 2
        step();                                      // cycle 3
        redirect    = 1'b1;
        redirect_pc = 32'h00000100;
        @(negedge clk);
        chk("t3_redir_req", {31'd0, imem_req}, 32'd0);
        chk("t3_redir_inst", inst_out, NOP_INST);
        step();                                      // cycle 4
        redirect = 1'b0;
        step();                                      // cycle 5
        step();                                      // cycle 6
        @(negedge clk);
        chk("t3_c6_inst", inst_out, NOP_INST);
        chk("t3_c6_pc4", pc4_out, 32'h0);
        step();                                      // cycle 7
        step();                                      // cycle 8
        @(negedge clk);
        chk("t3_c8_inst", inst_out, 32'h13000100);
        chk("t3_c8_pc4", pc4_out, 32'h00000104);

        // 4: redirect and stall together; redirect wins
        step();                                      // cycle 9, head 0x104 live
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h00000040;
        @(negedge clk);
        chk("t4_redir_valid", {31'd0, inst_valid}, 32'd0);
        chk("t4_redir_inst", inst_out, NOP_INST);
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (inst_valid) begin
                found = 1'b1;
                chk("t4_first_pc4", pc4_out, 32'h00000044);
                chk("t4_first_inst", inst_out, 32'h13000040);
            end
        end
        chk("t4_found_valid", {31'd0, found}, 32'd1);

        // 5: second instance, reset PC 0xFFFFFFF8 wraps through zero
        step();
        rst_b = 1'b0;                                // cycle 1
        @(negedge clk);
        chk("t5_c1_req", {31'd0, b_req}, 32'd1);
        chk("t5_c1_addr", b_addr, 32'hFFFFFFF8);
        step();                                      // cycle 2
        @(negedge clk);
        chk("t5_c2_addr", b_addr, 32'hFFFFFFFC);
        step();                                      // cycle 3
        @(negedge clk);
        chk("t5_c3_addr", b_addr, 32'h00000000);
        chk("t5_c3_pc4", b_pc4, 32'hFFFFFFFC);
        chk("t5_c3_inst", b_inst, 32'h13FFFFF8);
        step();                                      // cycle 4
        @(negedge clk);
        chk("t5_c4_pc4", b_pc4, 32'h00000000);
        step();                                      // cycle 5
        @(negedge clk);
        chk("t5_c5_pc4", b_pc4, 32'h00000004);
        chk("t5_c5_valid", {31'd0, b_valid}, 32'd1);

        // 6: reset with three words queued and one in flight
        step();
        rst   = 1'b1;
        lat   = 1;
        stall = 1'b1;
        step();
        rst = 1'b0;                                  // cycle 1
        repeat (3) step();                           // cycle 4
        @(negedge clk);
        chk("t6_c4_inst", inst_out, 32'h13000000);
        step();                                      // cycle 5: 3 queued + 1 in flight
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        step();                                      // cycle after reset
        rst   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("t6_post_valid", {31'd0, inst_valid}, 32'd0);
        chk("t6_post_inst", inst_out, NOP_INST);
        chk("t6_post_addr", imem_addr, 32'h00000000);
        chk("t6_post_req", {31'd0, imem_req}, 32'd1);
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
